// File: rtl/mccp_pkg.sv
// Shared definitions for the MCCP stack guard / context engine.
//   - cfg_sel encodings for the configuration register write port
//   - FSM state enum used by stack_guard_ctx
//   - default data/address width
package mccp_pkg;

  localparam int MCCP_WIDTH = 32;

  localparam logic [1:0] CFG_MY_STACK_BEGIN = 2'b00;
  localparam logic [1:0] CFG_MY_STACK_END   = 2'b01;
  localparam logic [1:0] CFG_STACK_BEGIN    = 2'b10;
  localparam logic [1:0] CFG_STACK_EXC_ADDR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_VECTOR  = 2'd3
  } state_e;

endpackage

// File: rtl/stack_window_check.sv
// Combinational stack-window fault compare.
// An access is illegal when it falls in the shared stack region (at or above
// stack_begin) but outside the core's own window [my_stack_begin, my_stack_end).
// All compares are unsigned.
//   addr           in  address under test
//   stack_begin    in  start of shared stack region
//   my_stack_begin in  start of this core's window (inclusive)
//   my_stack_end   in  end of this core's window (exclusive)
//   fault          out 1 = illegal access
module stack_window_check #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] stack_begin,
  input  logic [WIDTH-1:0] my_stack_begin,
  input  logic [WIDTH-1:0] my_stack_end,
  output logic             fault
);

  logic in_stack;
  logic in_window;

  always_comb begin
    in_stack  = (addr >= stack_begin);
    in_window = (addr >= my_stack_begin) && (addr < my_stack_end);
    fault     = in_stack && !in_window;
  end

endmodule

// File: rtl/stack_guard_ctx.sv
// Stack-protection and context save/restore engine.
// Checks core addresses against the stack windows; on a fault pushes NUM_REGS
// registers (reg[N-1] at sp+1 ... reg[0] at sp+N) and returns a handler vector.
// A restore pops reg[k] from sp-k for k = 0..N-1.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cfg_we/cfg_sel/cfg_data            config register write
//   chk_valid/chk_addr                 address check request (idle only)
//   chk_done/chk_fault                 check result pulse
//   restore_start                      start a pop (idle only)
//   sp_in / sp_out                     core sp in, updated sp with done
//   reg_rd_idx/reg_rd_data             register-file read (save)
//   reg_wr_en/reg_wr_idx/reg_wr_data   register-file write (restore)
//   mem_*                              request/response memory port
//   busy, done, handler_valid/addr     status and handler vector
module stack_guard_ctx
  import mccp_pkg::*;
#(
  parameter int  WIDTH    = MCCP_WIDTH,
  parameter int  NUM_REGS = 8,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_addr,
  output logic             chk_done,
  output logic             chk_fault,
  input  logic             restore_start,
  input  logic [WIDTH-1:0] sp_in,
  output logic [WIDTH-1:0] sp_out,
  output logic [IDX_W-1:0] reg_rd_idx,
  input  logic [WIDTH-1:0] reg_rd_data,
  output logic             reg_wr_en,
  output logic [IDX_W-1:0] reg_wr_idx,
  output logic [WIDTH-1:0] reg_wr_data,
  output logic             mem_request,
  output logic             mem_wren,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_writedata,
  input  logic             mem_response,
  input  logic [WIDTH-1:0] mem_readdata,
  output logic             busy,
  output logic             done,
  output logic             handler_valid,
  output logic [WIDTH-1:0] handler_addr
);

  localparam int             CW  = $clog2(NUM_REGS + 1);
  localparam logic [WIDTH-1:0] N_W = WIDTH'(NUM_REGS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;         // beats remaining, including the current one
  logic [WIDTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] my_begin_q, my_begin_d;
  logic [WIDTH-1:0] my_end_q, my_end_d;
  logic [WIDTH-1:0] stk_begin_q, stk_begin_d;
  logic [WIDTH-1:0] exc_q, exc_d;
  logic             req_q, req_d;
  logic             wren_q, wren_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;   // register feeding the next beat to be loaded
  logic             chk_done_q, chk_done_d;
  logic             chk_fault_q, chk_fault_d;
  logic             done_q, done_d;
  logic             hv_q, hv_d;
  logic [WIDTH-1:0] sp_out_q, sp_out_d;
  logic [WIDTH-1:0] haddr_q, haddr_d;
  logic             wr_en_q, wr_en_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             fault;

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
    return (i == '0) ? '0 : i - IDX_W'(1);
  endfunction

  stack_window_check #(.WIDTH(WIDTH)) u_check (
    .addr           (chk_addr),
    .stack_begin    (stk_begin_q),
    .my_stack_begin (my_begin_q),
    .my_stack_end   (my_end_q),
    .fault          (fault)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    my_begin_d  = my_begin_q;
    my_end_d    = my_end_q;
    stk_begin_d = stk_begin_q;
    exc_d       = exc_q;
    req_d       = req_q;
    wren_d      = wren_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_idx_d    = rd_idx_q;
    chk_done_d  = 1'b0;
    chk_fault_d = 1'b0;
    done_d      = 1'b0;
    hv_d        = 1'b0;
    sp_out_d    = sp_out_q;
    haddr_d     = haddr_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;

    // Config writes are taken in any state; the check uses the pre-write values.
    if (cfg_we) begin
      case (cfg_sel)
        CFG_MY_STACK_BEGIN: my_begin_d  = cfg_data;
        CFG_MY_STACK_END:   my_end_d    = cfg_data;
        CFG_STACK_BEGIN:    stk_begin_d = cfg_data;
        default:            exc_d       = cfg_data;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        // A check takes priority; a coincident restore_start is dropped.
        if (chk_valid) begin
          chk_done_d  = 1'b1;
          chk_fault_d = fault;
          if (fault) begin
            state_d  = ST_SAVE;
            sp_d     = sp_in;
            cnt_d    = CW'(NUM_REGS);
            rd_idx_d = IDX_W'(NUM_REGS - 1);
          end
        end else if (restore_start) begin
          state_d = ST_RESTORE;
          sp_d    = sp_in;
          cnt_d   = CW'(NUM_REGS);
        end
      end

      ST_SAVE: begin
        if (!req_q) begin
          // First beat: request rises one cycle after entry.
          req_d    = 1'b1;
          wren_d   = 1'b1;
          addr_d   = sp_q + WIDTH'(1);
          wdata_d  = reg_rd_data;
          rd_idx_d = idx_dec(rd_idx_q);
        end else if (mem_response) begin
          if (cnt_q == CW'(1)) begin
            req_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_VECTOR;
          end else begin
            // Next beat presented back-to-back, request stays high.
            cnt_d    = cnt_q - CW'(1);
            addr_d   = addr_q + WIDTH'(1);
            wdata_d  = reg_rd_data;
            rd_idx_d = idx_dec(rd_idx_q);
          end
        end
      end

      ST_VECTOR: begin
        done_d   = 1'b1;
        hv_d     = 1'b1;
        sp_out_d = sp_q + N_W;
        haddr_d  = exc_q;
        state_d  = ST_IDLE;
      end

      ST_RESTORE: begin
        if (!req_q) begin
          req_d  = 1'b1;
          wren_d = 1'b0;
          addr_d = sp_q;
        end else if (mem_response) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = IDX_W'(NUM_REGS - int'(cnt_q));
          wr_data_d = mem_readdata;
          if (cnt_q == CW'(1)) begin
            req_d    = 1'b0;
            cnt_d    = '0;
            done_d   = 1'b1;
            sp_out_d = sp_q - N_W;
            state_d  = ST_IDLE;
          end else begin
            cnt_d  = cnt_q - CW'(1);
            addr_d = addr_q - WIDTH'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sp_q        <= '0;
      my_begin_q  <= '1;
      my_end_q    <= '1;
      stk_begin_q <= '1;
      exc_q       <= '0;
      req_q       <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_idx_q    <= '0;
      chk_done_q  <= 1'b0;
      chk_fault_q <= 1'b0;
      done_q      <= 1'b0;
      hv_q        <= 1'b0;
      sp_out_q    <= '0;
      haddr_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      my_begin_q  <= my_begin_d;
      my_end_q    <= my_end_d;
      stk_begin_q <= stk_begin_d;
      exc_q       <= exc_d;
      req_q       <= req_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_idx_q    <= rd_idx_d;
      chk_done_q  <= chk_done_d;
      chk_fault_q <= chk_fault_d;
      done_q      <= done_d;
      hv_q        <= hv_d;
      sp_out_q    <= sp_out_d;
      haddr_q     <= haddr_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign chk_done      = chk_done_q;
  assign chk_fault     = chk_fault_q;
  assign sp_out        = sp_out_q;
  assign reg_rd_idx    = rd_idx_q;
  assign reg_wr_en     = wr_en_q;
  assign reg_wr_idx    = wr_idx_q;
  assign reg_wr_data   = wr_data_q;
  assign mem_request   = req_q;
  assign mem_wren      = wren_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign handler_valid = hv_q;
  assign handler_addr  = haddr_q;

endmodule

// File: tb/tb_stack_guard_ctx.sv
// Directed bench for stack_guard_ctx (WIDTH=32, NUM_REGS=8).
module tb_stack_guard_ctx;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        chk_valid;
  logic [31:0] chk_addr;
  logic        chk_done;
  logic        chk_fault;
  logic        restore_start;
  logic [31:0] sp_in;
  logic [31:0] sp_out;
  logic [2:0]  reg_rd_idx;
  logic [31:0] reg_rd_data;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic        mem_request;
  logic        mem_wren;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_response;
  logic [31:0] mem_readdata;
  logic        busy;
  logic        done;
  logic        handler_valid;
  logic [31:0] handler_addr;

  int passes = 0;
  int checks = 0;

  // Memory responder controls and logs
  bit          rand_en    = 1'b0;
  bit          force_resp = 1'b0;
  int          unstable   = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wren[$];
  logic [2:0]  wr_idx_log[$];
  logic [31:0] wr_data_log[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] regval(input int i);
    return 32'hA000_0000 + 32'(i * 32'h11);
  endfunction

  assign reg_rd_data = regval(int'(reg_rd_idx));

  stack_guard_ctx dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .chk_valid(chk_valid), .chk_addr(chk_addr),
    .chk_done(chk_done), .chk_fault(chk_fault),
    .restore_start(restore_start), .sp_in(sp_in), .sp_out(sp_out),
    .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .mem_request(mem_request), .mem_wren(mem_wren), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_response(mem_response),
    .mem_readdata(mem_readdata),
    .busy(busy), .done(done), .handler_valid(handler_valid),
    .handler_addr(handler_addr)
  );

  // Memory responder: decides response at the falling edge so the next rising
  // edge completes the beat; logs each completed beat and each reg write.
  initial begin
    bit          in_beat = 1'b0;
    int          wait_left = 0;
    logic [31:0] snap_a = '0;
    logic [31:0] snap_d = '0;
    logic        snap_w = 1'b0;
    mem_response = 1'b0;
    mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (reg_wr_en === 1'b1) begin
        wr_idx_log.push_back(reg_wr_idx);
        wr_data_log.push_back(reg_wr_data);
      end
      if (force_resp) begin
        mem_response = 1'b1;
      end else if (mem_request === 1'b1) begin
        if (in_beat && (mem_address !== snap_a || mem_writedata !== snap_d ||
                        mem_wren !== snap_w))
          unstable++;
        if (!in_beat) begin
          in_beat   = 1'b1;
          snap_a    = mem_address;
          snap_d    = mem_writedata;
          snap_w    = mem_wren;
          wait_left = rand_en ? int'($urandom_range(0, 3)) : 0;
        end
        if (wait_left == 0) begin
          mem_response = 1'b1;
          mem_readdata = 32'hD000_0000 | mem_address;
          log_addr.push_back(mem_address);
          log_data.push_back(mem_writedata);
          log_wren.push_back(mem_wren);
          in_beat = 1'b0;
        end else begin
          mem_response = 1'b0;
          wait_left--;
        end
      end else begin
        mem_response = 1'b0;
        in_beat      = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_chk(input logic [31:0] addr, input logic [31:0] sp);
    chk_valid = 1'b1; chk_addr = addr; sp_in = sp;
    tick();
    chk_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_wren.delete();
    wr_idx_log.delete(); wr_data_log.delete();
    unstable = 0;
  endtask

  task automatic check_save_log(input string tag);
    chk({tag, "_beats"}, 32'(log_addr.size()), 32'd8);
    chk({tag, "_stable"}, 32'(unstable), 32'd0);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      chk({tag, "_wren"}, {31'b0, log_wren[i]}, 32'd1);
      chk({tag, "_addr"}, log_addr[i], 32'h41 + 32'(i));
      chk({tag, "_data"}, log_data[i], regval(7 - i));
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = 2'b00; cfg_data = '0;
    chk_valid = 1'b0; chk_addr = '0; restore_start = 1'b0; sp_in = '0;
    tick(); tick();
    chk("rst_chk_done", {31'b0, chk_done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req", {31'b0, mem_request}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sp_out", sp_out, 32'd0);
    chk("rst_haddr", handler_addr, 32'd0);
    reset = 1'b0;
    tick();

    cfg(2'b10, 32'h100);
    cfg(2'b00, 32'h100);
    cfg(2'b01, 32'h140);
    cfg(2'b11, 32'h200);

    // Legal accesses: inside own window, below shared region, last window word
    clear_logs();
    do_chk(32'h120, 32'h40);
    chk("legal_done", {31'b0, chk_done}, 32'd1);
    chk("legal_fault", {31'b0, chk_fault}, 32'd0);
    chk("legal_busy", {31'b0, busy}, 32'd0);
    do_chk(32'h0FF, 32'h40);
    chk("below_fault", {31'b0, chk_done, chk_fault}, 32'd2);
    do_chk(32'h13F, 32'h40);
    chk("edge_fault", {31'b0, chk_done, chk_fault}, 32'd2);
    tick(); tick();
    chk("legal_noreq", {31'b0, mem_request}, 32'd0);
    chk("legal_nobeats", 32'(log_addr.size()), 32'd0);

    // Save, zero-wait memory
    do_chk(32'h180, 32'h40);
    chk("save_fault", {31'b0, chk_done, chk_fault}, 32'd3);
    chk("save_busy", {31'b0, busy}, 32'd1);
    chk("save_req_late", {31'b0, mem_request}, 32'd0);
    tick();
    chk("save_req_up", {31'b0, mem_request}, 32'd1);
    chk("save_addr1", mem_address, 32'h41);
    chk("save_data1", mem_writedata, regval(7));
    wait_done("save_done");
    chk("save_hv", {31'b0, handler_valid}, 32'd1);
    chk("save_haddr", handler_addr, 32'h200);
    chk("save_sp_out", sp_out, 32'h48);
    tick();
    chk("save_done_pulse", {31'b0, done, busy}, 32'd0);
    check_save_log("save");

    // Save under back-pressure; a check while busy is ignored
    clear_logs();
    rand_en = 1'b1;
    do_chk(32'h180, 32'h40);
    tick();
    do_chk(32'h120, 32'h40);
    chk("busy_ignore_chk", {31'b0, chk_done}, 32'd0);
    wait_done("bp_done");
    chk("bp_sp_out", sp_out, 32'h48);
    tick();
    check_save_log("bp");

    // Restore
    clear_logs();
    restore_start = 1'b1; sp_in = 32'h48;
    tick();
    restore_start = 1'b0;
    chk("rst_start_busy", {31'b0, busy, chk_done}, 32'd2);
    wait_done("restore_done");
    chk("restore_sp_out", sp_out, 32'h40);
    chk("restore_hv", {31'b0, handler_valid}, 32'd0);
    tick();
    chk("restore_beats", 32'(log_addr.size()), 32'd8);
    chk("restore_writes", 32'(wr_idx_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      chk("restore_wren", {31'b0, log_wren[i]}, 32'd0);
      chk("restore_addr", log_addr[i], 32'h48 - 32'(i));
    end
    for (int i = 0; i < 8 && i < wr_idx_log.size(); i++) begin
      chk("restore_idx", {29'b0, wr_idx_log[i]}, 32'(i));
      chk("restore_wdata", wr_data_log[i], 32'hD000_0048 - 32'(i));
    end
    chk("restore_stable", 32'(unstable), 32'd0);

    // Simultaneous check and restore: check wins, restore dropped
    rand_en = 1'b0;
    clear_logs();
    chk_valid = 1'b1; chk_addr = 32'h0FF; restore_start = 1'b1; sp_in = 32'h48;
    tick();
    chk_valid = 1'b0; restore_start = 1'b0;
    chk("simul_chk", {31'b0, chk_done, chk_fault}, 32'd2);
    chk("simul_busy", {31'b0, busy}, 32'd0);
    tick(); tick();
    chk("simul_idle", {31'b0, busy, mem_request}, 32'd0);

    // Response while request low is ignored
    force_resp = 1'b1;
    tick(); tick(); tick();
    force_resp = 1'b0;
    chk("stray_resp", {29'b0, busy, done, reg_wr_en}, 32'd0);
    chk("stray_nobeats", 32'(log_addr.size() + wr_idx_log.size()), 32'd0);

    // Reset after 3 save beats
    clear_logs();
    do_chk(32'h180, 32'h40);
    begin
      int n = 0;
      while (log_addr.size() < 3 && n < 100) begin
        tick();
        n++;
      end
    end
    chk("mid_3beats", {31'b0, log_addr.size() >= 3}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_req", {31'b0, mem_request}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    tick();
    do_chk(32'h180, 32'h40);
    chk("mid_default_cfg", {31'b0, chk_done, chk_fault}, 32'd2);
    tick();
    chk("mid_idle", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
